instr_fetch: RTL and testbench

Instruction fetch stage directly upstream of the control unit. Holds the program counter and instruction register, reads 20-bit instruction words from a synchronous instruction memory, and hands each word to the control unit with a one-cycle valid strobe. PC updates use the control unit's M3 encoding: increment, jump to gamma, or hold.

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/fetch_pc.sv | 59 +++++
 rtl/instr_fetch.sv | 126 ++++++++++++
 tb/tb_instr_fetch.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: definitions shared by the instruction fetch stage and its PC unit.
//   - PC source select codes (as driven by the control unit's M3 field)
//   - legal opcode range used to flag illegal instructions
//   - fetch FSM state type
package fetch_pkg;

  // PC source select. PC_TRAP is what the control unit drives on an
  // undecoded opcode; it behaves as a hold.
  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_JMP  = 2'b10;
  localparam logic [1:0] PC_TRAP = 2'b11;

  // The control unit decodes opcodes 0010..1110; everything outside is illegal.
  localparam logic [3:0] OPC_FIRST = 4'b0010;
  localparam logic [3:0] OPC_LAST  = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } fetch_state_e;

  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op < OPC_FIRST) || (op > OPC_LAST);
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// fetch_pc: program counter register with next-PC mux and sticky wrap flag.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   upd_i        apply an update this cycle (already qualified by the caller)
//   sel_i        PC source: hold / increment / load gamma / hold
//   gamma_i      jump target
//   pc_o         registered PC
//   pc_next_o    value the PC takes at the next edge (used for same-cycle fetch)
//   pc_wrap_o    sticky; set when an increment wraps all-ones to zero
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int PC_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            upd_i,
  input  logic [1:0]      sel_i,
  input  logic [PC_W-1:0] gamma_i,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pc_next_o,
  output logic            pc_wrap_o
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            wrap_q, wrap_d;

  always_comb begin
    pc_d   = pc_q;
    wrap_d = wrap_q;
    if (upd_i) begin
      case (sel_i)
        PC_INC: begin
          pc_d = pc_q + 1'b1;
          // Increment from all-ones rolls over to zero.
          if (&pc_q) wrap_d = 1'b1;
        end
        PC_JMP:           pc_d = gamma_i;
        PC_HOLD, PC_TRAP: pc_d = pc_q;
        default:          pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      wrap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      wrap_q <= wrap_d;
    end
  end

  assign pc_o      = pc_q;
  assign pc_next_o = pc_d;
  assign pc_wrap_o = wrap_q;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage feeding the control unit.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   fetch_req          request a fetch at the current PC (sampled in IDLE only)
//   pc_we, pc_sel      PC update strobe and source (accepted in IDLE only)
//   gamma              jump target
//   halt               blocks new fetches; an in-flight fetch still completes
//   imem_en/imem_addr  memory read request, one cycle per fetch
//   imem_rdata         memory data, valid MEM_LAT cycles after imem_en
//   instruction        instruction register, held until the next capture
//   instr_valid        one-cycle pulse after instruction is loaded
//   illegal            opcode outside 0010..1110, registered with instruction
//   pc, pc_wrap        current PC and sticky wrap flag
//   busy               high in every state except IDLE
// Handshake: no backpressure. A fetch is accepted on any IDLE cycle with
// fetch_req=1 and halt=0; the result is presented for exactly one cycle by
// instr_valid, and the consumer must take it then.
// MEM_LAT must be in 1..3 (the latency counter is two bits).
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int PC_W    = 6,
  parameter int INSTR_W = 20,
  parameter int MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_req,
  input  logic               pc_we,
  input  logic [1:0]         pc_sel,
  input  logic [PC_W-1:0]    gamma,
  input  logic               halt,
  output logic               imem_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic               illegal,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               pc_wrap
);

  // WAIT lasts MEM_LAT-1 cycles: counter loads MEM_LAT-2 and exits at zero.
  localparam logic [1:0] WAIT_INIT = (MEM_LAT > 1) ? 2'(MEM_LAT - 2) : 2'd0;

  fetch_state_e        state_q;
  logic [1:0]          lat_cnt_q;
  logic                imem_en_q;
  logic [PC_W-1:0]     imem_addr_q;
  logic [INSTR_W-1:0]  instr_q;
  logic                instr_valid_q;
  logic                illegal_q;
  logic                is_idle;
  logic                start_fetch;
  logic [PC_W-1:0]     pc_next;

  assign is_idle     = (state_q == ST_IDLE);
  assign start_fetch = is_idle && fetch_req && !halt;

  // PC updates are only honoured while idle, so an in-flight address never moves.
  fetch_pc #(
    .PC_W (PC_W)
  ) u_fetch_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .upd_i     (is_idle && pc_we),
    .sel_i     (pc_sel),
    .gamma_i   (gamma),
    .pc_o      (pc),
    .pc_next_o (pc_next),
    .pc_wrap_o (pc_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      lat_cnt_q     <= 2'd0;
      imem_en_q     <= 1'b0;
      imem_addr_q   <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      imem_en_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_fetch) begin
            state_q     <= ST_ISSUE;
            imem_en_q   <= 1'b1;
            // pc_next already includes a same-cycle PC update.
            imem_addr_q <= pc_next;
          end
        end
        ST_ISSUE: begin
          if (MEM_LAT > 1) begin
            state_q   <= ST_WAIT;
            lat_cnt_q <= WAIT_INIT;
          end else begin
            state_q <= ST_CAPTURE;
          end
        end
        ST_WAIT: begin
          if (lat_cnt_q == 2'd0) state_q <= ST_CAPTURE;
          else                   lat_cnt_q <= lat_cnt_q - 1'b1;
        end
        ST_CAPTURE: begin
          instr_q       <= imem_rdata;
          illegal_q     <= is_illegal_op(imem_rdata[INSTR_W-1 -: 4]);
          instr_valid_q <= 1'b1;
          state_q       <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign imem_en     = imem_en_q;
  assign imem_addr   = imem_addr_q;
  assign instruction = instr_q;
  assign instr_valid = instr_valid_q;
  assign illegal     = illegal_q;
  assign busy        = !is_idle;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: two instances (MEM_LAT=1 and MEM_LAT=3) share one
// stimulus stream, each with its own memory pipeline and reference model.
module tb_instr_fetch;

  localparam int DEPTH = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        fetch_req, pc_we, halt;
  logic [1:0]  pc_sel;
  logic [5:0]  gamma;

  logic        en0, en1, v0, v1, ill0, ill1, busy0, busy1, wrap0, wrap1;
  logic [5:0]  addr0, addr1, pc0, pc1;
  logic [19:0] rdata0, rdata1, instr0, instr1;

  instr_fetch #(.PC_W(6), .INSTR_W(20), .MEM_LAT(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc_we(pc_we),
    .pc_sel(pc_sel), .gamma(gamma), .halt(halt), .imem_en(en0),
    .imem_addr(addr0), .imem_rdata(rdata0), .instruction(instr0),
    .instr_valid(v0), .illegal(ill0), .pc(pc0), .busy(busy0), .pc_wrap(wrap0)
  );

  instr_fetch #(.PC_W(6), .INSTR_W(20), .MEM_LAT(3)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc_we(pc_we),
    .pc_sel(pc_sel), .gamma(gamma), .halt(halt), .imem_en(en1),
    .imem_addr(addr1), .imem_rdata(rdata1), .instruction(instr1),
    .instr_valid(v1), .illegal(ill1), .pc(pc1), .busy(busy1), .pc_wrap(wrap1)
  );

  // ---------------- synchronous instruction memories ----------------
  logic [19:0] mem [DEPTH];
  logic [19:0] pipe0;
  logic [19:0] pipe1 [3];

  always @(posedge clk) begin
    pipe0    <= en0 ? mem[addr0] : 20'h0;
    pipe1[0] <= en1 ? mem[addr1] : 20'h0;
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end
  assign rdata0 = pipe0;
  assign rdata1 = pipe1[2];

  // ---------------- reference model (transaction level) ----------------
  // Each fetch occupies the stage for lat+1 cycles after acceptance; the word
  // is delivered at the end of that window.
  int unsigned lat     [2] = '{1, 3};
  int unsigned m_pc    [2];
  int unsigned m_wrap  [2];
  int unsigned m_instr [2];
  int unsigned m_ill   [2];
  int unsigned m_valid [2];
  int unsigned m_left  [2];
  int unsigned m_addr  [2];
  int unsigned m_en    [2];

  task automatic model_update();
    int unsigned op;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_pc[k] = 0; m_wrap[k] = 0; m_instr[k] = 0; m_ill[k] = 0;
        m_valid[k] = 0; m_left[k] = 0; m_addr[k] = 0; m_en[k] = 0;
      end else begin
        m_valid[k] = 0;
        m_en[k]    = 0;
        if (m_left[k] == 0) begin
          if (pc_we && pc_sel == 2'b01) begin
            if (m_pc[k] == DEPTH - 1) m_wrap[k] = 1;
            m_pc[k] = (m_pc[k] + 1) % DEPTH;
          end else if (pc_we && pc_sel == 2'b10) begin
            m_pc[k] = gamma;
          end
          if (fetch_req && !halt) begin
            m_left[k] = lat[k] + 1;
            m_addr[k] = m_pc[k];
            m_en[k]   = 1;
          end
        end else begin
          m_left[k] = m_left[k] - 1;
          if (m_left[k] == 0) begin
            m_instr[k] = mem[m_addr[k]];
            op         = m_instr[k] >> 16;
            m_ill[k]   = (op < 2 || op == 15) ? 1 : 0;
            m_valid[k] = 1;
          end
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("L1 instruction", 32'(instr0), m_instr[0]);
    check("L1 instr_valid", 32'(v0),     m_valid[0]);
    check("L1 illegal",     32'(ill0),   m_ill[0]);
    check("L1 pc",          32'(pc0),    m_pc[0]);
    check("L1 busy",        32'(busy0),  (m_left[0] != 0) ? 32'd1 : 32'd0);
    check("L1 pc_wrap",     32'(wrap0),  m_wrap[0]);
    check("L1 imem_en",     32'(en0),    m_en[0]);
    check("L1 imem_addr",   32'(addr0),  m_addr[0]);
    check("L3 instruction", 32'(instr1), m_instr[1]);
    check("L3 instr_valid", 32'(v1),     m_valid[1]);
    check("L3 illegal",     32'(ill1),   m_ill[1]);
    check("L3 pc",          32'(pc1),    m_pc[1]);
    check("L3 busy",        32'(busy1),  (m_left[1] != 0) ? 32'd1 : 32'd0);
    check("L3 pc_wrap",     32'(wrap1),  m_wrap[1]);
    check("L3 imem_en",     32'(en1),    m_en[1]);
    check("L3 imem_addr",   32'(addr1),  m_addr[1]);
  endtask

  // ---------------- driver tasks ----------------
  // One clock: advance the model on the edge, compare on the falling edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic fr, input logic we, input logic [1:0] sel,
                       input logic [5:0] g, input logic h);
    fetch_req = fr; pc_we = we; pc_sel = sel; gamma = g; halt = h;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 2'b00, 6'd0, 1'b0);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- PC update vectors ----------------
  typedef struct {
    logic       we;
    logic [1:0] sel;
    logic [5:0] g;
    logic [5:0] exp_pc;
    logic       exp_wrap;
  } pc_vec_t;

  pc_vec_t vecs [9];

  initial begin
    int cnt;
    int vcnt;
    logic [19:0] w0;

    vecs[0] = '{1'b1, 2'b01, 6'd0,  6'd1,  1'b0};
    vecs[1] = '{1'b1, 2'b00, 6'd9,  6'd1,  1'b0};
    vecs[2] = '{1'b1, 2'b11, 6'd9,  6'd1,  1'b0};
    vecs[3] = '{1'b0, 2'b10, 6'd7,  6'd1,  1'b0};
    vecs[4] = '{1'b1, 2'b10, 6'd62, 6'd62, 1'b0};
    vecs[5] = '{1'b1, 2'b01, 6'd0,  6'd63, 1'b0};
    vecs[6] = '{1'b1, 2'b01, 6'd0,  6'd0,  1'b1};
    vecs[7] = '{1'b1, 2'b10, 6'd40, 6'd40, 1'b1};
    vecs[8] = '{1'b1, 2'b01, 6'd0,  6'd41, 1'b1};

    for (int i = 0; i < DEPTH; i++) mem[i] = 20'($urandom);
    mem[1] = 20'h430A5;
    mem[5] = 20'hF0000;
    w0     = mem[0];

    rst_n = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 6'd0, 1'b0);
    @(negedge clk);

    // Reset state.
    do_reset();
    check("reset pc",          32'(pc0),    32'd0);
    check("reset instruction", 32'(instr1), 32'd0);
    check("reset busy",        32'(busy1),  32'd0);
    check("reset pc_wrap",     32'(wrap0),  32'd0);
    check("reset imem_en",     32'(en0),    32'd0);

    // PC update table, applied while idle.
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, vecs[i].we, vecs[i].sel, vecs[i].g, 1'b0);
      step();
      drive(1'b0, 1'b0, 2'b00, 6'd0, 1'b0);
      check("vec pc",   32'(pc0),   32'(vecs[i].exp_pc));
      check("vec wrap", 32'(wrap1), 32'(vecs[i].exp_wrap));
    end

    // Increment then fetch mem[1], MEM_LAT=1 delivery at t+3.
    do_reset();
    drive(1'b0, 1'b1, 2'b01, 6'd0, 1'b0);
    step();
    check("A pc", 32'(pc0), 32'd1);
    drive(1'b1, 1'b0, 2'b00, 6'd0, 1'b0);
    step();
    drive(1'b0, 1'b0, 2'b00, 6'd0, 1'b0);
    check("A imem_en t+1",   32'(en0),   32'd1);
    check("A imem_addr t+1", 32'(addr0), 32'd1);
    step();
    check("A valid t+2", 32'(v0), 32'd0);
    step();
    check("A valid t+3",   32'(v0),     32'd1);
    check("A instruction", 32'(instr0), 32'h430A5);
    check("A illegal",     32'(ill0),   32'd0);
    step();
    check("A valid t+4",    32'(v0),     32'd0);
    check("A instr holds",  32'(instr0), 32'h430A5);
    for (int i = 0; i < 4; i++) step();

    // Jump and fetch in the same idle cycle.
    do_reset();
    drive(1'b1, 1'b1, 2'b10, 6'd40, 1'b0);
    step();
    drive(1'b0, 1'b0, 2'b00, 6'd0, 1'b0);
    check("B imem_addr L1", 32'(addr0), 32'd40);
    check("B imem_addr L3", 32'(addr1), 32'd40);
    check("B pc",           32'(pc0),   32'd40);
    for (int i = 0; i < 6; i++) step();

    // Wrap is sticky until reset.
    do_reset();
    drive(1'b0, 1'b1, 2'b10, 6'd63, 1'b0);
    step();
    drive(1'b0, 1'b1, 2'b01, 6'd0, 1'b0);
    step();
    check("C pc after wrap", 32'(pc0),   32'd0);
    check("C wrap set",      32'(wrap0), 32'd1);
    for (int i = 0; i < 10; i++) step();
    drive(1'b0, 1'b0, 2'b00, 6'd0, 1'b0);
    check("C pc after 10",   32'(pc1),   32'd10);
    check("C wrap sticky",   32'(wrap1), 32'd1);
    do_reset();
    check("C wrap cleared",  32'(wrap0), 32'd0);

    // Halt blocks fetch requests.
    drive(1'b1, 1'b0, 2'b00, 6'd0, 1'b1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      cnt += int'(en0) + int'(en1) + int'(busy0) + int'(busy1);
    end
    check("D halted activity", 32'(cnt), 32'd0);

    // Halt raised during ISSUE with MEM_LAT=3: delivered at t+5, nothing after.
    do_reset();
    drive(1'b1, 1'b0, 2'b00, 6'd0, 1'b0);
    step();
    drive(1'b1, 1'b0, 2'b00, 6'd0, 1'b1);
    vcnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      vcnt += int'(v1);
    end
    check("E early valid", 32'(vcnt), 32'd0);
    step();
    check("E valid t+5",   32'(v1),     32'd1);
    check("E instruction", 32'(instr1), 32'(w0));
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      cnt += int'(en0) + int'(en1);
    end
    check("E no refetch", 32'(cnt), 32'd0);

    // PC update during WAIT is ignored; illegal opcode F.
    do_reset();
    drive(1'b0, 1'b1, 2'b10, 6'd5, 1'b0);
    step();
    drive(1'b1, 1'b0, 2'b00, 6'd0, 1'b0);
    step();
    drive(1'b0, 1'b0, 2'b00, 6'd0, 1'b0);
    step();
    check("F busy in wait", 32'(busy1), 32'd1);
    drive(1'b0, 1'b1, 2'b10, 6'd33, 1'b0);
    step();
    drive(1'b0, 1'b0, 2'b00, 6'd0, 1'b0);
    check("F pc unchanged L3",   32'(pc1),   32'd5);
    check("F pc unchanged L1",   32'(pc0),   32'd5);
    check("F addr unchanged L3", 32'(addr1), 32'd5);
    step();
    step();
    check("F valid",       32'(v1),     32'd1);
    check("F instruction", 32'(instr1), 32'hF0000);
    check("F illegal",     32'(ill1),   32'd1);
    for (int i = 0; i < 3; i++) step();

    // Reset during WAIT discards the fetch; next fetch starts from pc=0.
    do_reset();
    drive(1'b0, 1'b1, 2'b10, 6'd9, 1'b0);
    step();
    drive(1'b1, 1'b0, 2'b00, 6'd0, 1'b0);
    step();
    drive(1'b0, 1'b0, 2'b00, 6'd0, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    check("G rst pc",          32'(pc1),    32'd0);
    check("G rst instruction", 32'(instr1), 32'd0);
    check("G rst valid",       32'(v1),     32'd0);
    check("G rst illegal",     32'(ill1),   32'd0);
    check("G rst imem_en",     32'(en1),    32'd0);
    check("G rst imem_addr",   32'(addr1),  32'd0);
    check("G rst busy",        32'(busy1),  32'd0);
    check("G rst pc_wrap",     32'(wrap1),  32'd0);
    step();
    rst_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      vcnt += int'(v1);
    end
    check("G no stale valid", 32'(vcnt), 32'd0);
    drive(1'b1, 1'b0, 2'b00, 6'd0, 1'b0);
    step();
    drive(1'b0, 1'b0, 2'b00, 6'd0, 1'b0);
    check("G addr after reset", 32'(addr1), 32'd0);
    check("G en after reset",   32'(en1),   32'd1);
    for (int i = 0; i < 4; i++) step();
    check("G valid after reset", 32'(v1),     32'd1);
    check("G instr after reset", 32'(instr1), 32'(w0));

    // Randomized stimulus against the model.
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3),
            2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
            ($urandom_range(0, 9) == 0));
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
